// File: rtl/scariv_dcache_bank_arbiter.sv
// ============================================================================
// scariv_dcache_bank_arbiter : per-bank round-robin arbitration of LSU pipes
// and the MISSU refill write port onto the DCACHE data banks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scariv_dcache_bank_arbiter #(
    parameter int REQ_NUM      = 3,
    parameter int BANKS        = 4,
    parameter int PADDR_W      = 56,
    parameter int BANK_LSB     = 5,
    parameter int STARVE_LIMIT = 4,
    localparam int BANK_W      = $clog2(BANKS),
    localparam int SRC_W       = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [REQ_NUM-1:0]               i_lsu_valid,
    input  logic [REQ_NUM-1:0][PADDR_W-1:0]  i_lsu_paddr,
    output logic [REQ_NUM-1:0]               o_lsu_gnt,
    output logic [REQ_NUM-1:0]               o_lsu_conflict,
    input  logic                             i_refill_valid,
    input  logic [PADDR_W-1:0]               i_refill_paddr,
    output logic                             o_refill_ready,
    output logic [BANKS-1:0]                 o_bank_valid,
    output logic [BANKS-1:0][PADDR_W-1:0]    o_bank_paddr,
    output logic [BANKS-1:0]                 o_bank_is_refill,
    output logic [BANKS-1:0][SRC_W-1:0]      o_bank_src
);

    logic [BANKS-1:0][REQ_NUM-1:0] w_req;
    logic [BANKS-1:0][SRC_W-1:0]   w_sel;
    logic [BANKS-1:0]              w_lsu_win;
    logic [BANKS-1:0]              w_refill_win;
    logic [BANK_W-1:0]             w_refill_bank;
    logic                          w_starved;

    logic [BANKS-1:0][SRC_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]              starve_q, starve_d;

    logic [BANKS-1:0]              bank_valid_q;
    logic [BANKS-1:0][PADDR_W-1:0] bank_paddr_q;
    logic [BANKS-1:0]              bank_is_refill_q;
    logic [BANKS-1:0][SRC_W-1:0]   bank_src_q;

    // Round-robin is done as two priority passes: first valid pipe at or above
    // the pointer, else the lowest-numbered valid pipe (the wrapped search).
    always_comb begin
        logic             found_hi;
        logic             found_lo;
        logic [SRC_W-1:0] sel_hi;
        logic [SRC_W-1:0] sel_lo;
        w_req         = '0;
        w_sel         = '0;
        w_lsu_win     = '0;
        w_refill_win  = '0;
        o_lsu_gnt     = '0;
        rr_d          = rr_q;
        found_hi      = 1'b0;
        found_lo      = 1'b0;
        sel_hi        = '0;
        sel_lo        = '0;
        w_starved     = (starve_q >= CNT_W'(STARVE_LIMIT));
        w_refill_bank = i_refill_paddr[BANK_LSB +: BANK_W];
        for (int b = 0; b < BANKS; b++) begin
            found_hi = 1'b0;
            found_lo = 1'b0;
            sel_hi   = '0;
            sel_lo   = '0;
            for (int i = 0; i < REQ_NUM; i++) begin
                w_req[b][i] = i_lsu_valid[i] &&
                              (i_lsu_paddr[i][BANK_LSB +: BANK_W] == BANK_W'(b));
                if (w_req[b][i]) begin
                    if (!found_lo) begin
                        found_lo = 1'b1;
                        sel_lo   = SRC_W'(i);
                    end
                    if (!found_hi && (i >= int'(rr_q[b]))) begin
                        found_hi = 1'b1;
                        sel_hi   = SRC_W'(i);
                    end
                end
            end
            w_sel[b]        = found_hi ? sel_hi : sel_lo;
            w_refill_win[b] = i_refill_valid && (w_refill_bank == BANK_W'(b)) &&
                              (w_starved || !found_lo);
            w_lsu_win[b]    = found_lo && !w_refill_win[b];
            if (w_lsu_win[b]) begin
                o_lsu_gnt[w_sel[b]] = 1'b1;
                rr_d[b] = (w_sel[b] == SRC_W'(REQ_NUM - 1)) ? '0 : w_sel[b] + 1'b1;
            end
        end
    end

    assign o_lsu_conflict = i_lsu_valid & ~o_lsu_gnt;
    assign o_refill_ready = |w_refill_win;

    always_comb begin
        starve_d = starve_q;
        if (!i_refill_valid || o_refill_ready) begin
            starve_d = '0;
        end else if (!w_starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Payload fields hold when a bank has no winner; only valid drops.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_q             <= '0;
            starve_q         <= '0;
            bank_valid_q     <= '0;
            bank_paddr_q     <= '0;
            bank_is_refill_q <= '0;
            bank_src_q       <= '0;
        end else begin
            rr_q         <= rr_d;
            starve_q     <= starve_d;
            bank_valid_q <= w_refill_win | w_lsu_win;
            for (int b = 0; b < BANKS; b++) begin
                if (w_refill_win[b]) begin
                    bank_paddr_q[b]     <= i_refill_paddr;
                    bank_is_refill_q[b] <= 1'b1;
                    bank_src_q[b]       <= '0;
                end else if (w_lsu_win[b]) begin
                    bank_paddr_q[b]     <= i_lsu_paddr[w_sel[b]];
                    bank_is_refill_q[b] <= 1'b0;
                    bank_src_q[b]       <= w_sel[b];
                end
            end
        end
    end

    assign o_bank_valid     = bank_valid_q;
    assign o_bank_paddr     = bank_paddr_q;
    assign o_bank_is_refill = bank_is_refill_q;
    assign o_bank_src       = bank_src_q;

endmodule

`default_nettype wire

// File: doc/scariv_dcache_bank_arbiter.md
Name: scariv_dcache_bank_arbiter

Overview:
- Shares the DCACHE_BANKS data-cache banks between REQ_NUM LSU pipes and the single MISSU refill-write port.
- Per bank, each cycle: selects at most one winner. LSU pipes are rotated round-robin; refill is normally lowest priority, with a starvation guard.
- Grants and conflicts are reported combinationally to the LSU pipes and MISSU. The selected bank command is registered into the banks.
- Sits between the LSU pipeline request stage and the DCACHE bank arrays.

Parameters:
- REQ_NUM, 3, number of LSU pipes (matches LSU_INST_NUM).
- BANKS, 4, number of DCACHE banks; power of two, at least 2.
- PADDR_W, 56, physical address width.
- BANK_LSB, 5, lowest paddr bit of the bank index (32-byte line, DCACHE_DATA_W=256).
- STARVE_LIMIT, 4, consecutive refill losses before refill is forced to win.

Ports:
- i_clk, input, 1, clock.
- i_reset_n, input, 1, asynchronous active-low reset.
- i_lsu_valid, input, REQ_NUM, per-pipe request valid.
- i_lsu_paddr, input, REQ_NUM x PADDR_W, per-pipe physical address.
- o_lsu_gnt, output, REQ_NUM, request granted this cycle (combinational).
- o_lsu_conflict, output, REQ_NUM, valid request lost arbitration and must replay (combinational).
- i_refill_valid, input, 1, MISSU refill write request; held until ready.
- i_refill_paddr, input, PADDR_W, refill line address.
- o_refill_ready, output, 1, refill accepted this cycle (combinational).
- o_bank_valid, output, BANKS, registered per-bank command valid.
- o_bank_paddr, output, BANKS x PADDR_W, registered per-bank address.
- o_bank_is_refill, output, BANKS, registered; 1 means the command is a refill write.
- o_bank_src, output, BANKS x clog2(REQ_NUM), registered winning LSU index; 0 when is_refill.

Behaviour:
- Bank index = paddr[BANK_LSB +: clog2(BANKS)]; applies to LSU and refill alike.
- Per bank b, candidates are the valid LSU pipes mapping to b, plus refill if it maps to b.
- LSU selection per bank: round-robin starting from rr_ptr[b]. Search order is rr_ptr[b], rr_ptr[b]+1, ... modulo REQ_NUM.
- Refill vs LSU per bank:
  - If starve_cnt >= STARVE_LIMIT, refill wins bank b.
  - Otherwise refill wins only if no LSU candidate exists for b.
- At most one grant per bank per cycle. Requests to different banks are all granted in the same cycle.
- o_lsu_gnt[i]=1 iff pipe i won its bank. o_lsu_conflict[i] = i_lsu_valid[i] & ~o_lsu_gnt[i]. Both are 0 when the pipe is not valid.
- o_refill_ready=1 iff refill won its bank.
- rr_ptr[b] update, on an LSU grant to pipe i in bank b: rr_ptr[b] <= (i+1) mod REQ_NUM. Otherwise it holds. Reset value 0.
- starve_cnt (clog2(STARVE_LIMIT+1) bits):
  - Reset to 0.
  - Cleared on o_refill_ready or when i_refill_valid=0.
  - Incremented, saturating at STARVE_LIMIT, when i_refill_valid=1 and o_refill_ready=0.
- Bank command registers are loaded every cycle with that cycle's winner. This gives 1-cycle latency from grant to o_bank_*.
- o_bank_valid[b]=0 the cycle after no winner. o_bank_paddr, o_bank_src and o_bank_is_refill hold their previous values when not valid.
- Reset values: o_bank_valid=0, o_bank_paddr=0, o_bank_is_refill=0, o_bank_src=0, rr_ptr=0, starve_cnt=0.
- Combinational outputs follow inputs even during reset; the banks ignore them because o_bank_valid is held 0.
- Reset asserted mid-operation: all registers clear asynchronously; a pending refill is re-arbitrated from starve_cnt=0 after release.
- Refill protocol: MISSU must hold i_refill_valid and i_refill_paddr stable until o_refill_ready. Address changes while waiting are not supported.
- No state machine beyond rr_ptr and starve_cnt. No buffering: every lost LSU request is a replay, never queued.

Test Plan:
- Reset: hold i_reset_n=0 with all requests active -> o_bank_valid=0000; after release, pipes 0,1,2 to banks 0,1,2 -> o_lsu_gnt=111, conflict=000, next cycle o_bank_valid=0111 with src 0,1,2.
- Round-robin fairness: pipes 0,1,2 all to bank 1 for 3 cycles -> grants 0, then 1, then 2; conflicts 110, 101, 011; o_bank_src[1] sequence 0,1,2 one cycle later.
- Refill low priority: refill to bank 2, no LSU on bank 2 -> o_refill_ready=1 same cycle; next cycle o_bank_is_refill[2]=1, o_bank_src[2]=0.
- Starvation guard: refill plus pipe 0 to bank 3 every cycle -> pipe 0 wins 4 cycles (starve_cnt 0..3, then 4); 5th cycle o_refill_ready=1, o_lsu_conflict=001; starve_cnt returns to 0.
- Mixed banks: pipe0 bank 0, pipe1 bank 0, pipe2 bank 3, refill bank 1 -> gnt=101, conflict=010, refill_ready=1; next cycle o_bank_valid=1011.
- Async reset mid-stream: assert i_reset_n=0 between edges while starve_cnt=3 -> o_bank_valid drops to 0 immediately; after release, refill needs a full 4 losses before forced priority.
